// File: rtl/sd_image_rd_ctrl.sv
// sd_image_rd_ctrl
//   Reads back the most recently saved image from the SD card. It first reads
//   the index sector to get the saved-image count N, then streams the
//   SEC_LENGTH sectors of slot N-1 into the 16w32r FIFO, one sector at a time.
//   A sector read is only started when the SD engines are idle and the FIFO
//   has room for a whole sector.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   sd_init_done                card ready; low aborts to IDLE
//   sys_image_read_req          one-cycle read-back request
//   wr_busy, rd_busy            SD write/read engine busy
//   rd_data, rd_data_valid      SD read data stream
//   fifo_wr_cnt                 FIFO write-side fill level (words)
//   rd_start_en, rd_sec_addr    sector read start pulse and address
//   fifo_wr_en, fifo_wr_data    FIFO push
//   rd_image_busy/done/err      status: busy, done pulse, sticky error
//   o_state                     FSM state (debug)
module sd_image_rd_ctrl #(
  parameter int unsigned SEC_LENGTH     = 2000,
  parameter int unsigned SLOT_STRIDE    = 2000,
  parameter int unsigned INDEX_SEC_ADDR = 0,
  parameter int unsigned SEC_WORDS      = 256,
  parameter int unsigned FIFO_DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        sys_image_read_req,
  input  logic        wr_busy,
  input  logic        rd_busy,
  input  logic [15:0] rd_data,
  input  logic        rd_data_valid,
  input  logic [10:0] fifo_wr_cnt,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic        rd_image_busy,
  output logic        rd_image_done,
  output logic        rd_image_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IDX_REQ  = 3'd1,
    IDX_WAIT = 3'd2,
    CALC     = 3'd3,
    SEC_REQ  = 3'd4,
    SEC_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [10:0] CNT_LIMIT = 11'(FIFO_DEPTH - SEC_WORDS);
  localparam logic [8:0]  WORDS_EXP = 9'(SEC_WORDS);
  localparam logic [11:0] SECS_EXP  = 12'(SEC_LENGTH);
  localparam logic [31:0] IDX_ADDR  = 32'(INDEX_SEC_ADDR);
  localparam logic [31:0] STRIDE    = 32'(SLOT_STRIDE);

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] num_q, num_d;
  logic        num_vld_q, num_vld_d;
  logic [31:0] base_q, base_d;
  logic [11:0] sec_cnt_q, sec_cnt_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic        rd_busy_d0_q;

  logic        sd_busy;
  logic        sec_end;
  logic [8:0]  word_inc;
  logic [8:0]  word_tot;
  logic [11:0] sec_next;

  assign sd_busy  = rd_busy | wr_busy;
  assign sec_end  = rd_busy_d0_q & ~rd_busy;
  assign word_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 9'd1;
  // A word arriving in the same cycle as the busy fall still belongs to the sector.
  assign word_tot = rd_data_valid ? word_inc : word_cnt_q;
  assign sec_next = sec_cnt_q + 12'd1;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | (sys_image_read_req & ~busy_q);
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = 1'b0;
    start_d    = 1'b0;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    num_d      = num_q;
    num_vld_d  = num_vld_q;
    base_d     = base_q;
    sec_cnt_d  = sec_cnt_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      IDLE: begin
        if (pending_q && !sd_busy) begin
          pending_d = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = IDX_REQ;
        end
      end
      IDX_REQ: begin
        if (!sd_busy) begin
          start_d   = 1'b1;
          addr_d    = IDX_ADDR;
          num_d     = '0;
          num_vld_d = 1'b0;
          state_d   = IDX_WAIT;
        end
      end
      IDX_WAIT: begin
        if (rd_data_valid && !num_vld_q) begin
          num_d     = rd_data;
          num_vld_d = 1'b1;
        end
        if (sec_end) state_d = CALC;
      end
      CALC: begin
        if (num_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          base_d    = ({16'd0, num_q} - 32'd1) * STRIDE + 32'd1;
          sec_cnt_d = '0;
          state_d   = SEC_REQ;
        end
      end
      SEC_REQ: begin
        if (!sd_busy && (fifo_wr_cnt <= CNT_LIMIT)) begin
          start_d    = 1'b1;
          addr_d     = base_q + {20'd0, sec_cnt_q};
          word_cnt_d = '0;
          state_d    = SEC_WAIT;
        end
      end
      SEC_WAIT: begin
        if (rd_data_valid) begin
          wr_en_d    = 1'b1;
          wr_data_d  = rd_data;
          word_cnt_d = word_inc;
        end
        if (sec_end) begin
          if (word_tot != WORDS_EXP) err_d = 1'b1;
          sec_cnt_d = sec_next;
          if (sec_next == SECS_EXP) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SEC_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!sd_init_done) begin
      state_d   = IDLE;
      pending_d = 1'b0;
      busy_d    = 1'b0;
      start_d   = 1'b0;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      num_q        <= '0;
      num_vld_q    <= 1'b0;
      base_q       <= '0;
      sec_cnt_q    <= '0;
      word_cnt_q   <= '0;
      rd_busy_d0_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      done_q       <= done_d;
      start_q      <= start_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      num_q        <= num_d;
      num_vld_q    <= num_vld_d;
      base_q       <= base_d;
      sec_cnt_q    <= sec_cnt_d;
      word_cnt_q   <= word_cnt_d;
      rd_busy_d0_q <= rd_busy;
    end
  end

  assign rd_start_en   = start_q;
  assign rd_sec_addr   = addr_q;
  assign fifo_wr_en    = wr_en_q;
  assign fifo_wr_data  = wr_data_q;
  assign rd_image_busy = busy_q;
  assign rd_image_done = done_q;
  assign rd_image_err  = err_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_sd_image_rd_ctrl.sv
// Bench for sd_image_rd_ctrl: an SD read-engine model answers sector reads,
// expected addresses / FIFO words / done status are queued per request and a
// monitor compares them against what the DUT presents.
module tb_sd_image_rd_ctrl;

  localparam int unsigned SEC_LEN = 4;
  localparam int unsigned STRIDE  = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_init_done;
  logic        sys_image_read_req;
  logic        wr_busy;
  logic        rd_busy;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic [10:0] fifo_wr_cnt;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        rd_image_busy;
  logic        rd_image_done;
  logic        rd_image_err;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  sd_image_rd_ctrl #(
    .SEC_LENGTH(SEC_LEN),
    .SLOT_STRIDE(STRIDE),
    .INDEX_SEC_ADDR(0),
    .SEC_WORDS(256),
    .FIFO_DEPTH(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done),
    .sys_image_read_req(sys_image_read_req), .wr_busy(wr_busy),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .fifo_wr_cnt(fifo_wr_cnt), .rd_start_en(rd_start_en),
    .rd_sec_addr(rd_sec_addr), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .rd_image_busy(rd_image_busy),
    .rd_image_done(rd_image_done), .rd_image_err(rd_image_err),
    .o_state(o_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_push   = 0;
  int n_done   = 0;

  logic [31:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic        exp_err_q[$];

  logic [15:0] n_val      = '0;
  logic [31:0] short_addr = '1;
  logic [15:0] seed       = '0;
  bit          hold_cnt   = 1'b0;

  function automatic logic [15:0] word_of(input logic [31:0] addr, input int i);
    if (addr == 0 && i == 0) return n_val;
    return 16'(addr * 32'd97) ^ 16'(i * 13) ^ seed;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Reference: one index read, then SEC_LEN sectors from slot N-1.
  task automatic expect_image(input int n, input logic [31:0] sh);
    logic [31:0] base;
    logic [31:0] a;
    int nw;
    n_val      = 16'(n);
    short_addr = sh;
    exp_addr_q.push_back(32'd0);
    if (n == 0) begin
      exp_err_q.push_back(1'b1);
    end else begin
      base = 32'(n - 1) * STRIDE + 32'd1;
      for (int s = 0; s < int'(SEC_LEN); s++) begin
        a  = base + 32'(s);
        nw = (a == sh) ? 255 : 256;
        exp_addr_q.push_back(a);
        for (int i = 0; i < nw; i++) exp_data_q.push_back(word_of(a, i));
      end
      exp_err_q.push_back((sh >= base) && (sh < base + SEC_LEN));
    end
  endtask

  // SD read engine model
  initial begin : sd_model
    logic [31:0] a;
    int nw;
    int g;
    rd_busy = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_data_valid = 1'b0;
      if (rst_n && rd_start_en) begin
        a  = rd_sec_addr;
        nw = (a == short_addr) ? 255 : 256;
        rd_busy = 1'b1;
        for (int i = 0; i < nw; i++) begin
          g = $urandom_range(0, 2);
          repeat (g) begin
            @(negedge clk);
            rd_data_valid = 1'b0;
          end
          @(negedge clk);
          rd_data_valid = 1'b1;
          rd_data = word_of(a, i);
        end
        @(negedge clk);
        rd_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rd_busy = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        rd_data_valid = 1'b1;
        rd_data = 16'($urandom);
      end
    end
  end

  initial begin : fifo_level
    fifo_wr_cnt = '0;
    forever begin
      @(negedge clk);
      if (!hold_cnt) fifo_wr_cnt = 11'($urandom_range(0, 900));
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rd_start_en) begin
          n_start++;
          check("start_while_sd_busy", {62'd0, rd_busy, wr_busy}, 64'd0);
          if (exp_addr_q.size() == 0) fail_now("unexpected_start");
          else check("start_addr", rd_sec_addr, exp_addr_q.pop_front());
        end
        if (fifo_wr_en) begin
          n_push++;
          if (exp_data_q.size() == 0) fail_now("unexpected_push");
          else check("push_data", fifo_wr_data, exp_data_q.pop_front());
        end
        if (rd_image_done) begin
          n_done++;
          check("done_busy_low", rd_image_busy, 0);
          if (exp_err_q.size() == 0) fail_now("unexpected_done");
          else check("done_err", rd_image_err, exp_err_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_req();
    @(negedge clk);
    sys_image_read_req = 1'b1;
    @(negedge clk);
    sys_image_read_req = 1'b0;
  endtask

  task automatic wait_busy();
    int t = 0;
    while (!rd_image_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("busy_raised", rd_image_busy, 1);
    check("err_cleared_on_accept", rd_image_err, 0);
  endtask

  task automatic finish_image();
    int d0 = n_done;
    int s0;
    int t = 0;
    while (n_done == d0 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", n_done - d0, 1);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("data_q_empty", exp_data_q.size(), 0);
    check("err_q_empty", exp_err_q.size(), 0);
    s0 = n_start;
    repeat (30) @(negedge clk);
    check("idle_after_done_starts", n_start - s0, 0);
    check("idle_after_done_busy", rd_image_busy, 0);
  endtask

  task automatic wait_sd_idle();
    int t = 0;
    while (rd_busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("sd_model_idle", rd_busy, 0);
  endtask

  initial begin : stim
    int s0, p0, d0, t, n;
    rst_n = 1'b0;
    sd_init_done = 1'b0;
    sys_image_read_req = 1'b0;
    wr_busy = 1'b0;
    seed = 16'($urandom);
    repeat (3) @(negedge clk);
    check("rst_start", rd_start_en, 0);
    check("rst_addr", rd_sec_addr, 0);
    check("rst_push", fifo_wr_en, 0);
    check("rst_data", fifo_wr_data, 0);
    check("rst_busy", rd_image_busy, 0);
    check("rst_done", rd_image_done, 0);
    check("rst_err", rd_image_err, 0);
    check("rst_state", o_state, 0);
    rst_n = 1'b1;
    sd_init_done = 1'b1;
    repeat (3) @(negedge clk);

    // N=3, plus a second request while busy that must be ignored
    expect_image(3, '1);
    pulse_req();
    wait_busy();
    repeat (10) @(negedge clk);
    pulse_req();
    finish_image();

    // empty card
    expect_image(0, '1);
    pulse_req();
    wait_busy();
    finish_image();
    check("empty_err_sticky", rd_image_err, 1);

    // short sector in sector 2 of slot 2
    expect_image(3, 32'd4003);
    pulse_req();
    wait_busy();
    finish_image();
    check("short_err_sticky", rd_image_err, 1);

    // random slots; err must clear on accept
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 40);
      expect_image(n, '1);
      pulse_req();
      wait_busy();
      finish_image();
      check("rand_err_clear", rd_image_err, 0);
    end

    // FIFO throttle at 769 / 768
    @(negedge clk);
    hold_cnt = 1'b1;
    fifo_wr_cnt = 11'd769;
    expect_image(1, '1);
    pulse_req();
    t = 0;
    while (o_state != 3'd4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("reach_sec_req", o_state, 4);
    s0 = n_start;
    repeat (20) @(negedge clk);
    check("throttle_hold", n_start - s0, 0);
    fifo_wr_cnt = 11'd768;
    @(posedge clk);
    #1;
    check("throttle_release", rd_start_en, 1);
    finish_image();
    hold_cnt = 1'b0;

    // write engine busy at request
    @(negedge clk);
    wr_busy = 1'b1;
    expect_image(2, '1);
    pulse_req();
    s0 = n_start;
    repeat (30) @(negedge clk);
    check("wr_busy_no_start", n_start - s0, 0);
    check("wr_busy_not_accepted", rd_image_busy, 0);
    wr_busy = 1'b0;
    wait_busy();
    finish_image();

    // sd_init_done falls mid-sector
    expect_image(2, '1);
    pulse_req();
    wait_busy();
    p0 = n_push;
    t = 0;
    while (n_push < p0 + 300 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reach_mid_sector", o_state, 5);
    sd_init_done = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err_q.delete();
    @(posedge clk);
    #1;
    check("abort_state", o_state, 0);
    check("abort_busy", rd_image_busy, 0);
    check("abort_push", fifo_wr_en, 0);
    s0 = n_start;
    p0 = n_push;
    d0 = n_done;
    repeat (300) @(negedge clk);
    check("abort_no_push", n_push - p0, 0);
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_start", n_start - s0, 0);
    wait_sd_idle();
    sd_init_done = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_restart", n_start - s0, 0);

    // request coincident with init fall is dropped
    @(negedge clk);
    sd_init_done = 1'b0;
    sys_image_read_req = 1'b1;
    @(negedge clk);
    sys_image_read_req = 1'b0;
    sd_init_done = 1'b1;
    s0 = n_start;
    repeat (30) @(negedge clk);
    check("init_wins_no_start", n_start - s0, 0);
    check("init_wins_idle", rd_image_busy, 0);

    // recovery after abort
    expect_image(5, '1);
    pulse_req();
    wait_busy();
    finish_image();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
